p2s_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one parallel-to-serial transmitter (13-bit packet: parity, data byte, preamble, shifted LSB first) among several byte requesters. It grants one requester at a time and forwards up to MAX_BURST bytes as a single burst on the transmitter's valid/data inputs. It then waits for the transmitter's busy cycle to rise and fall before granting again. It sits between the requester-side logic and the transmitter instance.

---
 rtl/p2s_tx_arbiter.sv | 117 +++++++++++
 tb/tb_p2s_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_tx_arbiter.sv
// p2s_tx_arbiter: round-robin arbiter that forwards bursts of requester bytes
// into one shared parallel-to-serial transmitter, then waits out its busy cycle.
module p2s_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int MAX_BURST    = 5,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [8*N_REQ-1:0]       data_i,
   output logic [N_REQ-1:0]         ack_o,
   output logic                     gnt_vld_o,
   output logic [$clog2(N_REQ)-1:0] gnt_id_o,
   output logic                     tx_en_o,
   output logic [7:0]               tx_data_o,
   input  logic                     tx_busy_i,
   output logic                     err_o
);
   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(MAX_BURST + 1);
   localparam int TW  = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_BURST);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, BURST, WAIT_BUSY, WAIT_DONE} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nxt;
   logic [IDW-1:0] winner;
   logic           found;
   logic [CW-1:0]  cnt;
   logic [TW-1:0]  tmo;
   logic           req_gnt;
   logic           ack_gnt;
   logic [7:0]     data_gnt;

   // Search ptr, ptr+1, ... wrapping, and keep the first requester found.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_i[IDW'(idx)]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   assign req_gnt  = req_i[gnt_id_o];
   assign data_gnt = data_i[{gnt_id_o, 3'b000} +: 8];
   assign ack_gnt  = (state == BURST) && req_gnt && (cnt < CNT_MAX);
   assign ptr_nxt  = (gnt_id_o == ID_LAST) ? '0 : gnt_id_o + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!tx_busy_i && found) state_nxt = BURST;
         BURST: begin
            if (ack_gnt && cnt == CNT_LAST) state_nxt = WAIT_BUSY;
            else if (!req_gnt)              state_nxt = (cnt == '0) ? IDLE : WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy_i)            state_nxt = WAIT_DONE;
            else if (tmo == TMO_LAST) state_nxt = IDLE;
         end
         WAIT_DONE: if (!tx_busy_i) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ack_o     = '0;
      gnt_vld_o = (state != IDLE);
      if (ack_gnt) ack_o[gnt_id_o] = 1'b1;
   end

   // A withdrawn zero-byte grant also returns through here, so ptr still advances.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr       <= '0;
         gnt_id_o  <= '0;
         cnt       <= '0;
         tmo       <= '0;
         tx_en_o   <= 1'b0;
         tx_data_o <= '0;
         err_o     <= 1'b0;
      end else begin
         tx_en_o <= ack_gnt;
         err_o   <= (state == WAIT_BUSY) && (state_nxt == IDLE);
         if (ack_gnt) begin
            tx_data_o <= data_gnt;
            cnt       <= cnt + 1'b1;
         end
         if (state == IDLE && state_nxt == BURST) begin
            gnt_id_o <= winner;
            cnt      <= '0;
         end
         if (state == WAIT_BUSY) tmo <= tmo + 1'b1;
         else                    tmo <= '0;
         if (state != IDLE && state_nxt == IDLE) ptr <= ptr_nxt;
      end
   end
endmodule

// File: tb/tb_p2s_tx_arbiter.sv
// tb_p2s_tx_arbiter: requesters are byte queues, the transmitter is a busy-pulse
// model, and expected grants/bytes come from a transaction-level round-robin model.
module tb_p2s_tx_arbiter;
   localparam int N    = 4;
   localparam int MAXB = 5;
   localparam int TMO  = 4;

   typedef struct {
      int         prime;
      logic [3:0] mask;
      int         exp_winner;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] data = '0;
   logic [N-1:0]   ack;
   logic           gnt_vld;
   logic [1:0]     gnt_id;
   logic           tx_en;
   logic [7:0]     tx_data;
   logic           tx_busy = 1'b0;
   logic           err;

   p2s_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .BUSY_TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .ack_o(ack),
      .gnt_vld_o(gnt_vld), .gnt_id_o(gnt_id), .tx_en_o(tx_en), .tx_data_o(tx_data),
      .tx_busy_i(tx_busy), .err_o(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int violations = 0;
   logic [7:0] q [N][$];
   logic [7:0] model_q [N][$];
   bit manual_mode, busy_force, busy_enable, busy_rand, prev_gnt;
   logic [N-1:0] manual_req;
   logic [7:0] manual_data;
   int busy_hold, busy_cnt, cur_run, last_tx_cycle, first_ack_cycle, first_tx_cycle;
   int ack_count [N];
   int grant_log[$], grant_cycle[$], err_cycle[$], run_log[$], stream_id[$];
   logic [7:0] stream_byte[$];
   int exp_grant[$], exp_id[$], exp_run[$];
   logic [7:0] exp_byte[$];
   vec_t vecs [8];

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < N; k++) if (q[k].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_logs();
      grant_log.delete(); grant_cycle.delete(); err_cycle.delete(); run_log.delete();
      stream_id.delete(); stream_byte.delete();
      prev_gnt = 1'b0; cur_run = 0; last_tx_cycle = -1; first_ack_cycle = -1; first_tx_cycle = -1;
      for (int k = 0; k < N; k++) ack_count[k] = 0;
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         if (manual_mode) begin
            req[k] = manual_req[k];
            data[k*8 +: 8] = manual_data;
         end else begin
            req[k] = (q[k].size() > 0);
            data[k*8 +: 8] = (q[k].size() > 0) ? q[k][0] : 8'h00;
         end
      end
   endtask

   // One clock: drive inputs after the edge, then sample and log outputs.
   task automatic apply_stimulus();
      @(posedge clk);
      #1;
      cycle++;
      drive_inputs();
      tx_busy = busy_force || (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      #1;
      if (tx_en && tx_busy) violations++;
      if (gnt_vld && !prev_gnt) begin
         grant_log.push_back(int'(gnt_id));
         grant_cycle.push_back(cycle);
      end
      prev_gnt = gnt_vld;
      if (ack != '0 && first_ack_cycle < 0) first_ack_cycle = cycle;
      if (tx_en) begin
         if (first_tx_cycle < 0) first_tx_cycle = cycle;
         last_tx_cycle = cycle;
         cur_run++;
         stream_id.push_back(int'(gnt_id));
         stream_byte.push_back(tx_data);
      end else if (cur_run > 0) begin
         run_log.push_back(cur_run);
         cur_run = 0;
         if (busy_enable) busy_cnt = busy_rand ? int'($urandom_range(1, 8)) : busy_hold;
      end
      if (err) err_cycle.push_back(cycle);
      if (!manual_mode) begin
         for (int k = 0; k < N; k++) begin
            if (ack[k] && q[k].size() > 0) begin
               void'(q[k].pop_front());
               ack_count[k]++;
            end
         end
      end
   endtask

   task automatic reset_dut();
      manual_mode = 0; busy_force = 0; busy_enable = 1; busy_rand = 0;
      busy_hold = 3; busy_cnt = 0; manual_req = '0; manual_data = '0;
      req = '0; data = '0; tx_busy = 1'b0;
      for (int k = 0; k < N; k++) q[k].delete();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      clear_logs();
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         apply_stimulus();
         n++;
         done = all_empty() && !gnt_vld && busy_cnt == 0 && !tx_busy && cur_run == 0;
      end
      if (!done) check_output({name, "_drain_timeout"}, 1, 0);
   endtask

   task automatic exp_clear();
      exp_grant.delete(); exp_id.delete(); exp_run.delete(); exp_byte.delete();
   endtask

   // Transaction-level model: each grant takes min(remaining, MAXB) bytes from the
   // first non-empty queue at or after ptr; ptr then moves past the winner.
   task automatic build_expected(input int start_ptr);
      int ptr, win, n;
      ptr = start_ptr;
      exp_clear();
      for (int k = 0; k < N; k++) model_q[k] = q[k];
      while (1) begin
         win = -1;
         for (int i = 0; i < N; i++)
            if (win < 0 && model_q[(ptr + i) % N].size() > 0) win = (ptr + i) % N;
         if (win < 0) break;
         n = (model_q[win].size() < MAXB) ? model_q[win].size() : MAXB;
         exp_grant.push_back(win);
         exp_run.push_back(n);
         for (int j = 0; j < n; j++) begin
            exp_id.push_back(win);
            exp_byte.push_back(model_q[win].pop_front());
         end
         ptr = (win + 1) % N;
      end
   endtask

   task automatic compare_model(input string name);
      check_output({name, "_grant_count"}, grant_log.size(), exp_grant.size());
      for (int i = 0; i < exp_grant.size() && i < grant_log.size(); i++)
         check_output($sformatf("%s_grant%0d", name, i), grant_log[i], exp_grant[i]);
      check_output({name, "_byte_count"}, stream_byte.size(), exp_byte.size());
      for (int i = 0; i < exp_byte.size() && i < stream_byte.size(); i++) begin
         check_output($sformatf("%s_byte%0d", name, i), int'(stream_byte[i]), int'(exp_byte[i]));
         check_output($sformatf("%s_id%0d", name, i), stream_id[i], exp_id[i]);
      end
      check_output({name, "_run_count"}, run_log.size(), exp_run.size());
      for (int i = 0; i < exp_run.size() && i < run_log.size(); i++)
         check_output($sformatf("%s_run%0d", name, i), run_log[i], exp_run[i]);
   endtask

   initial begin
      int t, n, bad;
      vecs[0] = '{0, 4'b1111, 1};
      vecs[1] = '{1, 4'b0011, 0};
      vecs[2] = '{3, 4'b1000, 3};
      vecs[3] = '{2, 4'b0100, 2};
      vecs[4] = '{3, 4'b0110, 1};
      vecs[5] = '{0, 4'b1001, 3};
      vecs[6] = '{2, 4'b1001, 3};
      vecs[7] = '{3, 4'b0101, 0};

      reset_dut();
      check_output("rst_ack", int'(ack), 0);
      check_output("rst_gnt_vld", int'(gnt_vld), 0);
      check_output("rst_gnt_id", int'(gnt_id), 0);
      check_output("rst_tx_en", int'(tx_en), 0);
      check_output("rst_tx_data", int'(tx_data), 0);
      check_output("rst_err", int'(err), 0);

      // Single requester, three bytes, long busy.
      q[0].push_back(8'hA5); q[0].push_back(8'h3C); q[0].push_back(8'hFF);
      busy_hold = 39;
      apply_stimulus();
      t = cycle;
      drain("basic", 200);
      check_output("basic_grant_latency", (grant_cycle.size() > 0) ? grant_cycle[0] - t : -1, 1);
      check_output("basic_ack_latency", first_ack_cycle - t, 1);
      check_output("basic_tx_latency", first_tx_cycle - t, 2);
      exp_clear();
      exp_grant.push_back(0); exp_run.push_back(3);
      exp_byte.push_back(8'hA5); exp_byte.push_back(8'h3C); exp_byte.push_back(8'hFF);
      for (int i = 0; i < 3; i++) exp_id.push_back(0);
      compare_model("basic");
      clear_logs();
      busy_hold = 3;
      for (int k = 0; k < N; k++) q[k].push_back(8'h40 + 8'(k));
      build_expected(1);
      drain("after_basic", 400);
      check_output("ptr_after_basic", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
      compare_model("after_basic");

      // All four requesting six bytes each.
      reset_dut();
      for (int k = 0; k < N; k++)
         for (int j = 0; j < 6; j++) q[k].push_back(8'(16 * k + j));
      build_expected(0);
      drain("burst_rr", 1000);
      compare_model("burst_rr");

      // Table of round-robin decisions from a primed pointer.
      for (int r = 0; r < 8; r++) begin
         reset_dut();
         q[vecs[r].prime].push_back(8'h20);
         drain($sformatf("prime%0d", r), 200);
         clear_logs();
         for (int k = 0; k < N; k++) if (vecs[r].mask[k]) q[k].push_back(8'h30 + 8'(k));
         drain($sformatf("vec%0d", r), 400);
         check_output($sformatf("rr_vec%0d", r), (grant_log.size() > 0) ? grant_log[0] : -1, vecs[r].exp_winner);
      end

      // Zero-byte grant: request withdrawn before the first ack.
      reset_dut();
      manual_mode = 1; manual_req = 4'b0100; manual_data = 8'h77;
      apply_stimulus();
      manual_req = '0;
      apply_stimulus();
      check_output("zero_gnt_vld", int'(gnt_vld), 1);
      check_output("zero_gnt_id", int'(gnt_id), 2);
      check_output("zero_ack", int'(ack), 0);
      apply_stimulus();
      check_output("zero_back_idle", int'(gnt_vld), 0);
      repeat (6) apply_stimulus();
      check_output("zero_no_tx", first_tx_cycle, -1);
      check_output("zero_no_err", err_cycle.size(), 0);
      manual_mode = 0;
      clear_logs();
      for (int k = 0; k < N; k++) q[k].push_back(8'h50 + 8'(k));
      drain("after_zero", 400);
      check_output("ptr_after_zero", (grant_log.size() > 0) ? grant_log[0] : -1, 3);

      // Busy never rises after a full burst.
      reset_dut();
      busy_enable = 0;
      for (int j = 0; j < 5; j++) q[1].push_back(8'h60 + 8'(j));
      repeat (30) apply_stimulus();
      check_output("tmo_err_count", err_cycle.size(), 1);
      check_output("tmo_err_delay", (err_cycle.size() > 0) ? err_cycle[0] - last_tx_cycle : -1, TMO);
      check_output("tmo_run", (run_log.size() > 0) ? run_log[0] : -1, 5);
      busy_enable = 1;
      clear_logs();
      q[0].push_back(8'h5A);
      exp_clear();
      exp_grant.push_back(0); exp_run.push_back(1); exp_byte.push_back(8'h5A); exp_id.push_back(0);
      drain("after_tmo", 200);
      compare_model("after_tmo");

      // Transmitter busy while idle blocks the grant.
      reset_dut();
      busy_force = 1;
      q[1].push_back(8'hC3);
      bad = 0;
      repeat (8) begin
         apply_stimulus();
         if (ack != '0 || gnt_vld) bad++;
      end
      check_output("busy_blocks_grant", bad, 0);
      busy_force = 0;
      apply_stimulus();
      apply_stimulus();
      check_output("busy_release_gnt_vld", int'(gnt_vld), 1);
      check_output("busy_release_gnt_id", int'(gnt_id), 1);
      drain("busy_release", 200);

      // Reset in the middle of a burst.
      reset_dut();
      for (int j = 0; j < 5; j++) q[2].push_back(8'h90 + 8'(j));
      n = 0;
      while (ack_count[2] < 2 && n < 20) begin
         apply_stimulus();
         n++;
      end
      if (ack_count[2] < 2) check_output("midrst_reach", ack_count[2], 2);
      rst = 1'b1;
      #1;
      check_output("midrst_ack", int'(ack), 0);
      check_output("midrst_gnt_vld", int'(gnt_vld), 0);
      check_output("midrst_gnt_id", int'(gnt_id), 0);
      check_output("midrst_tx_en", int'(tx_en), 0);
      check_output("midrst_tx_data", int'(tx_data), 0);
      check_output("midrst_err", int'(err), 0);
      q[1].push_back(8'h11);
      drive_inputs();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      clear_logs();
      build_expected(0);
      drain("post_rst", 400);
      check_output("post_rst_lowest", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
      compare_model("post_rst");

      // Randomized queues and busy lengths against the model.
      for (int it = 0; it < 6; it++) begin
         reset_dut();
         busy_rand = 1;
         for (int k = 0; k < N; k++) begin
            n = $urandom_range(0, 12);
            for (int j = 0; j < n; j++) q[k].push_back(8'($urandom_range(0, 255)));
         end
         build_expected(0);
         drain($sformatf("rand%0d", it), 3000);
         compare_model($sformatf("rand%0d", it));
         check_output($sformatf("rand%0d_no_err", it), err_cycle.size(), 0);
      end

      check_output("tx_en_during_busy", violations, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
